// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding, default operand geometry and index-width helper.
package rsa_pkg;
   typedef enum logic {ST_IDLE, ST_SEND} state_t;
   localparam int DEF_WIDTH = 4096;
   localparam int DEF_WORD  = 32;
   // A single-word operand still needs a one-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wide_shift_reg.sv
// wide_shift_reg: WIDTH-bit shadow register unloaded WORD bits at a time.
// RSA_UNLOAD_MSW_FIRST_EN selects most-significant word first (shift left) instead of LS first.
module wide_shift_reg #(
   parameter int WIDTH = 4096,
   parameter int WORD  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic [WORD-1:0]  dout
);
   logic [WIDTH-1:0] q;
`ifdef RSA_UNLOAD_MSW_FIRST_EN
   assign dout = q[WIDTH-1 -: WORD];
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= q << WORD;
`else
   assign dout = q[WORD-1:0];
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= q >> WORD;
`endif
endmodule

// File: rtl/wide_reg_unloader.sv
// wide_reg_unloader: captures a WIDTH-bit operand and streams it out as WIDTH/WORD words over valid/ready.
// Word order set by RSA_UNLOAD_MSW_FIRST_EN in wide_shift_reg; out_idx always counts transmission order.
module wide_reg_unloader
   import rsa_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int WORD  = DEF_WORD,
   localparam int NWORDS = WIDTH / WORD,
   localparam int IW = idx_width(NWORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WORD-1:0]  out_data,
   output logic [IW-1:0]    out_idx,
   output logic             out_last,
   output logic             done
);
   if (WIDTH % WORD != 0) begin : g_bad_geometry
      $error("wide_reg_unloader: WIDTH must be a multiple of WORD");
   end

   state_t state;
   logic   xfer, load;

   assign xfer = out_valid & out_ready;
   assign load = (state == ST_IDLE) & load_en;

   wide_shift_reg #(.WIDTH(WIDTH), .WORD(WORD)) u_shadow (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(xfer),
      .din  (load_data),
      .dout (out_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE:
               if (load_en) begin
                  state     <= ST_SEND;
                  busy      <= 1'b1;
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_last  <= (NWORDS == 1);
               end
            ST_SEND:
               if (xfer) begin
                  if (out_last) begin
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_idx   <= '0;
                     done      <= 1'b1;
                  end else begin
                     out_idx  <= out_idx + IW'(1);
                     out_last <= (out_idx == IW'(NWORDS - 2));
                  end
               end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_reg_unloader.sv
// tb_wide_reg_unloader: table-driven check of wide_reg_unloader at WIDTH=128, WORD=32.
// Expected word order follows RSA_UNLOAD_MSW_FIRST_EN so the same bench covers both builds.
module tb_wide_reg_unloader;
   logic         clk = 1'b0;
   logic         rst, load_en, out_ready;
   logic [127:0] load_data;
   logic         busy, out_valid, out_last, done;
   logic [31:0]  out_data;
   logic [1:0]   out_idx;

   localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] D2 = 128'h88888888_77777777_66666666_55555555;
`ifdef RSA_UNLOAD_MSW_FIRST_EN
   localparam logic [31:0] A0 = 32'h44444444, A1 = 32'h33333333, A2 = 32'h22222222, A3 = 32'h11111111;
   localparam logic [31:0] B0 = 32'h88888888, B1 = 32'h77777777, B2 = 32'h66666666, B3 = 32'h55555555;
`else
   localparam logic [31:0] A0 = 32'h11111111, A1 = 32'h22222222, A2 = 32'h33333333, A3 = 32'h44444444;
   localparam logic [31:0] B0 = 32'h55555555, B1 = 32'h66666666, B2 = 32'h77777777, B3 = 32'h88888888;
`endif

   int tests = 0, fails = 0;

   wide_reg_unloader #(.WIDTH(128), .WORD(32)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done)
   );

   always #5 clk = ~clk;

   // Inputs applied for one cycle; expected outputs just after the following rising edge.
   typedef struct {
      logic         r, ld, rdy;
      logic [127:0] din;
      logic         bsy, vld;
      logic [31:0]  dat;
      logic [1:0]   idx;
      logic         lst, dn;
   } vec_t;
   vec_t v[$];

   function automatic void add(input logic r, ld, input logic [127:0] din, input logic rdy,
                               input logic bsy, vld, input logic [31:0] dat, input logic [1:0] idx,
                               input logic lst, dn);
      v.push_back('{r: r, ld: ld, rdy: rdy, din: din, bsy: bsy, vld: vld, dat: dat, idx: idx, lst: lst, dn: dn});
   endfunction

   function automatic void idle(input logic rdy, input logic dn);
      add(0, 0, '0, rdy, 0, 0, 32'h0, 2'd0, 0, dn);
   endfunction

   task automatic step(input logic r, ld, input logic [127:0] din, input logic rdy);
      @(negedge clk);
      rst = r; load_en = ld; load_data = din; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      logic [31:0] got[4];
      rst = 1'b1; load_en = 1'b0; load_data = '0; out_ready = 1'b0;
      // reset state
      add(1, 0, '0, 0, 0, 0, 32'h0, 2'd0, 0, 0);
      // test 1: full-rate stream, done the cycle after the last word
      add(0, 1, D1, 1, 1, 1, A0, 2'd0, 0, 0);
      add(0, 0, '0, 1, 1, 1, A1, 2'd1, 0, 0);
      add(0, 0, '0, 1, 1, 1, A2, 2'd2, 0, 0);
      add(0, 0, '0, 1, 1, 1, A3, 2'd3, 1, 0);
      idle(1, 1);
      idle(1, 0);
      // test 2: back-pressure holds word, idx and last
      add(0, 1, D1, 0, 1, 1, A0, 2'd0, 0, 0);
      add(0, 0, '0, 0, 1, 1, A0, 2'd0, 0, 0);
      add(0, 0, '0, 1, 1, 1, A1, 2'd1, 0, 0);
      add(0, 0, '0, 0, 1, 1, A1, 2'd1, 0, 0);
      add(0, 0, '0, 0, 1, 1, A1, 2'd1, 0, 0);
      add(0, 0, '0, 1, 1, 1, A2, 2'd2, 0, 0);
      add(0, 0, '0, 0, 1, 1, A2, 2'd2, 0, 0);
      add(0, 0, '0, 1, 1, 1, A3, 2'd3, 1, 0);
      add(0, 0, '0, 0, 1, 1, A3, 2'd3, 1, 0);
      idle(1, 1);
      // test 3: load_en during SEND is ignored
      add(0, 1, D1, 1, 1, 1, A0, 2'd0, 0, 0);
      add(0, 1, D2, 1, 1, 1, A1, 2'd1, 0, 0);
      add(0, 1, D2, 0, 1, 1, A1, 2'd1, 0, 0);
      add(0, 1, D2, 1, 1, 1, A2, 2'd2, 0, 0);
      add(0, 1, D2, 1, 1, 1, A3, 2'd3, 1, 0);
      idle(1, 1);
      // test 5: load in the done cycle is accepted back-to-back
      add(0, 1, D2, 1, 1, 1, B0, 2'd0, 0, 0);
      add(0, 0, '0, 1, 1, 1, B1, 2'd1, 0, 0);
      add(0, 0, '0, 1, 1, 1, B2, 2'd2, 0, 0);
      add(0, 0, '0, 1, 1, 1, B3, 2'd3, 1, 0);
      idle(1, 1);
      // test 4: reset after two transfers aborts with no done pulse
      add(0, 1, D1, 1, 1, 1, A0, 2'd0, 0, 0);
      add(0, 0, '0, 1, 1, 1, A1, 2'd1, 0, 0);
      add(0, 0, '0, 1, 1, 1, A2, 2'd2, 0, 0);
      add(1, 0, '0, 1, 0, 0, 32'h0, 2'd0, 0, 0);
      idle(1, 0);
      idle(1, 0);
      add(0, 1, D2, 1, 1, 1, B0, 2'd0, 0, 0);
      add(0, 0, '0, 1, 1, 1, B1, 2'd1, 0, 0);
      add(0, 0, '0, 1, 1, 1, B2, 2'd2, 0, 0);
      add(0, 0, '0, 1, 1, 1, B3, 2'd3, 1, 0);
      idle(1, 1);
      idle(1, 0);

      step(1, 0, '0, 0);
      foreach (v[i]) begin
         step(v[i].r, v[i].ld, v[i].din, v[i].rdy);
         tests++;
         if ({busy, out_valid, out_data, out_idx, out_last, done} !==
             {v[i].bsy, v[i].vld, v[i].dat, v[i].idx, v[i].lst, v[i].dn}) begin
            fails++;
            $display("FAIL row%0d: got busy=%b valid=%b data=%h idx=%0d last=%b done=%b, want busy=%b valid=%b data=%h idx=%0d last=%b done=%b",
                     i, busy, out_valid, out_data, out_idx, out_last, done,
                     v[i].bsy, v[i].vld, v[i].dat, v[i].idx, v[i].lst, v[i].dn);
         end
      end

      // load-to-done latency with out_ready tied high is NWORDS+1 = 5 cycles
      step(0, 1, D2, 1);
      cyc = 1;
      while (!done && cyc < 20) begin
         if (out_valid) got[out_idx] = out_data;
         step(0, 0, '0, 1);
         cyc++;
      end
      tests++;
      if (cyc != 5 || !done) begin
         fails++;
         $display("FAIL latency: got %0d cycles (done=%b), want 5", cyc, done);
      end
      tests++;
      if ({got[0], got[1], got[2], got[3]} !== {B0, B1, B2, B3}) begin
         fails++;
         $display("FAIL order: got %h %h %h %h, want %h %h %h %h",
                  got[0], got[1], got[2], got[3], B0, B1, B2, B3);
      end
      step(0, 0, '0, 1);
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse: got done=%b one cycle later, want 0", done);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
